// File: rtl/lcd_text_driver.sv
// HD44780 2x16 character LCD driver (4-bit, write-only): power-on init, nibble timing, 32-char frame refresh.
// Optional build macro LCD_AUTO_REFRESH_EN adds a periodic refresh request every T_REFRESH cycles.
module lcd_text_driver #(
    parameter int T_PWRUP   = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_E_HI    = 12,
    parameter int T_HOLD    = 2,
    parameter int T_NIB_GAP = 50,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_REFRESH = 2500000
) (
    input  logic         CCLK,
    input  logic         rst,
    input  logic         strobe,
    input  logic [255:0] text,
    output logic         busy,
    output logic         LCDRS,
    output logic         LCDRW,
    output logic         LCDE,
    output logic [3:0]   LCDDAT
);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} top_t;
    typedef enum logic [2:0] {E_IDLE, E_SETUP, E_HI, E_LO, E_GAP, E_WAIT} eng_t;

    top_t         top_reg;
    eng_t         eng_reg;
    logic [31:0]  timer_reg;
    logic [2:0]   step_reg;
    logic [3:0]   col_reg;
    logic         issued_reg;
    logic         low_reg;
    logic         pending_reg;
    logic [255:0] frame_reg;
    logic [7:0]   cur_byte_reg;
    logic         cur_single_reg;
    logic [31:0]  cur_post_reg;

    logic         req;
    logic [7:0]   job_byte;
    logic         job_rs;
    logic         job_single;
    logic [31:0]  job_post;
    logic [4:0]   char_idx;

    assign LCDRW = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
    logic        ar_run_reg;
    logic [31:0] ar_cnt_reg;
    logic        auto_req_reg;

    // Period counter starts once init has completed and free-runs from then on.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            ar_run_reg   <= 1'b0;
            ar_cnt_reg   <= 32'd0;
            auto_req_reg <= 1'b0;
        end else begin
            auto_req_reg <= 1'b0;
            if (top_reg != PWR_WAIT && top_reg != INIT)
                ar_run_reg <= 1'b1;
            if (ar_run_reg) begin
                if (ar_cnt_reg == 32'(T_REFRESH - 1)) begin
                    ar_cnt_reg   <= 32'd0;
                    auto_req_reg <= 1'b1;
                end else begin
                    ar_cnt_reg <= ar_cnt_reg + 32'd1;
                end
            end
        end
    end

    assign req = strobe | auto_req_reg;
`else
    assign req = strobe;
`endif

    // Byte to send for the current top state; single-nibble init writes use the high nibble only.
    always_comb begin
        job_byte   = 8'h00;
        job_rs     = 1'b0;
        job_single = 1'b0;
        job_post   = 32'(T_CMD);
        char_idx   = {top_reg == LINE2, col_reg};
        case (top_reg)
            INIT: begin
                case (step_reg)
                    3'd0, 3'd1, 3'd2: begin job_byte = 8'h30; job_single = 1'b1; end
                    3'd3:             begin job_byte = 8'h20; job_single = 1'b1; end
                    3'd4:             job_byte = 8'h28;
                    3'd5:             job_byte = 8'h06;
                    3'd6:             job_byte = 8'h0C;
                    default:          begin job_byte = 8'h01; job_post = 32'(T_CLEAR); end
                endcase
            end
            ADDR1:        job_byte = 8'h80;
            ADDR2:        job_byte = 8'hC0;
            LINE1, LINE2: begin
                job_byte = frame_reg[{~char_idx, 3'b000} +: 8];
                job_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            top_reg        <= PWR_WAIT;
            eng_reg        <= E_IDLE;
            timer_reg      <= 32'd0;
            step_reg       <= 3'd0;
            col_reg        <= 4'd0;
            issued_reg     <= 1'b0;
            low_reg        <= 1'b0;
            pending_reg    <= 1'b0;
            frame_reg      <= '0;
            cur_byte_reg   <= 8'h00;
            cur_single_reg <= 1'b0;
            cur_post_reg   <= 32'd0;
            busy           <= 1'b1;
            LCDRS          <= 1'b0;
            LCDE           <= 1'b0;
            LCDDAT         <= 4'h0;
        end else begin
            if (req && busy)
                pending_reg <= 1'b1;
            case (eng_reg)
                E_IDLE: begin
                    case (top_reg)
                        PWR_WAIT: begin
                            if (timer_reg == 32'(T_PWRUP - 1)) begin
                                timer_reg <= 32'd0;
                                top_reg   <= INIT;
                                step_reg  <= 3'd0;
                            end else begin
                                timer_reg <= timer_reg + 32'd1;
                            end
                        end
                        IDLE: begin
                            if (req) begin
                                frame_reg <= text;
                                top_reg   <= ADDR1;
                                busy      <= 1'b1;
                            end
                        end
                        default: begin
                            if (!issued_reg) begin
                                cur_byte_reg   <= job_byte;
                                cur_single_reg <= job_single;
                                cur_post_reg   <= job_post;
                                LCDRS          <= job_rs;
                                LCDDAT         <= job_byte[7:4];
                                low_reg        <= 1'b0;
                                timer_reg      <= 32'd0;
                                eng_reg        <= E_SETUP;
                                issued_reg     <= 1'b1;
                            end else begin
                                issued_reg <= 1'b0;
                                // End of init or LINE2 either returns to IDLE or chains a queued refresh.
                                if ((top_reg == INIT && step_reg == 3'd7) ||
                                    (top_reg == LINE2 && col_reg == 4'd15)) begin
                                    col_reg <= 4'd0;
                                    if (pending_reg || req) begin
                                        pending_reg <= 1'b0;
                                        frame_reg   <= text;
                                        top_reg     <= ADDR1;
                                    end else begin
                                        top_reg <= IDLE;
                                        busy    <= 1'b0;
                                    end
                                end else begin
                                    case (top_reg)
                                        INIT:  step_reg <= step_reg + 3'd1;
                                        ADDR1: top_reg  <= LINE1;
                                        LINE1: begin
                                            col_reg <= col_reg + 4'd1;
                                            if (col_reg == 4'd15)
                                                top_reg <= ADDR2;
                                        end
                                        ADDR2: top_reg  <= LINE2;
                                        LINE2: col_reg  <= col_reg + 4'd1;
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    endcase
                end
                E_SETUP: begin
                    if (timer_reg == 32'(T_SETUP - 1)) begin
                        timer_reg <= 32'd0;
                        LCDE      <= 1'b1;
                        eng_reg   <= E_HI;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                E_HI: begin
                    if (timer_reg == 32'(T_E_HI - 1)) begin
                        timer_reg <= 32'd0;
                        LCDE      <= 1'b0;
                        eng_reg   <= E_LO;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                E_LO: begin
                    if (timer_reg == 32'(T_HOLD - 1)) begin
                        timer_reg <= 32'd0;
                        eng_reg   <= (!cur_single_reg && !low_reg) ? E_GAP : E_WAIT;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                E_GAP: begin
                    if (timer_reg == 32'(T_NIB_GAP - 1)) begin
                        timer_reg <= 32'd0;
                        low_reg   <= 1'b1;
                        LCDDAT    <= cur_byte_reg[3:0];
                        eng_reg   <= E_SETUP;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                E_WAIT: begin
                    if (timer_reg == cur_post_reg - 32'd1) begin
                        timer_reg <= 32'd0;
                        eng_reg   <= E_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                end
                default: eng_reg <= E_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Self-checking bench for lcd_text_driver: pulse-level monitor plus a byte-list reference model of the LCD traffic.
module tb_lcd_text_driver;

    localparam int T_PWRUP   = 10;
    localparam int T_SETUP   = 2;
    localparam int T_E_HI    = 3;
    localparam int T_HOLD    = 2;
    localparam int T_NIB_GAP = 3;
    localparam int T_CMD     = 4;
    localparam int T_CLEAR   = 4;
    localparam int T_REFRESH = 1000;

    logic         CCLK = 1'b0;
    logic         rst = 1'b1;
    logic         strobe = 1'b0;
    logic [255:0] text = '0;
    logic         busy, LCDRS, LCDRW, LCDE;
    logic [3:0]   LCDDAT;

    int n_tests = 0;
    int n_fail = 0;
    int timing_err = 0;
    int cyc = 0;

    logic [4:0] pulses[$];
    logic [4:0] exp_q[$];

    lcd_text_driver #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_E_HI(T_E_HI), .T_HOLD(T_HOLD),
        .T_NIB_GAP(T_NIB_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .T_REFRESH(T_REFRESH)
    ) dut (
        .CCLK(CCLK), .rst(rst), .strobe(strobe), .text(text), .busy(busy),
        .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDE(LCDE), .LCDDAT(LCDDAT)
    );

    always #5 CCLK = ~CCLK;
    always @(posedge CCLK) cyc <= cyc + 1;

    // Pin monitor: records {RS,DAT} at every LCDE rise and counts timing violations.
    initial begin
        logic [4:0] sig, last_sig;
        logic last_e;
        int stable, since_fall, hi_cnt;
        last_sig = '0; last_e = 1'b0; stable = 0; since_fall = 1000; hi_cnt = 0;
        forever begin
            @(negedge CCLK);
            sig = {LCDRS, LCDDAT};
            if (LCDRW !== 1'b0) timing_err++;
            if (rst) begin
                last_sig = sig; last_e = LCDE; stable = 0; since_fall = 1000; hi_cnt = 0;
            end else begin
                if (sig !== last_sig) begin
                    if (LCDE || last_e || since_fall < T_HOLD) timing_err++;
                    stable = 1;
                end else begin
                    stable++;
                end
                if (LCDE && !last_e) begin
                    if (stable - 1 < T_SETUP) timing_err++;
                    pulses.push_back(sig);
                    hi_cnt = 1;
                    since_fall = 0;
                end else if (LCDE) begin
                    hi_cnt++;
                end else if (last_e) begin
                    if (hi_cnt != T_E_HI) timing_err++;
                    since_fall = 1;
                end else begin
                    since_fall++;
                end
                last_sig = sig;
                last_e = LCDE;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic model_init();
        exp_q.push_back(5'h03); exp_q.push_back(5'h03);
        exp_q.push_back(5'h03); exp_q.push_back(5'h02);
        model_byte(1'b0, 8'h28); model_byte(1'b0, 8'h06);
        model_byte(1'b0, 8'h0C); model_byte(1'b0, 8'h01);
    endtask

    task automatic model_refresh(input logic [255:0] t);
        model_byte(1'b0, 8'h80);
        for (int c = 0; c < 16; c++) model_byte(1'b1, t[255 - 8*c -: 8]);
        model_byte(1'b0, 8'hC0);
        for (int c = 0; c < 16; c++) model_byte(1'b1, t[127 - 8*c -: 8]);
    endtask

    task automatic compare_model(input string tag);
        int n;
        chk({tag, "_count"}, 64'(pulses.size()), 64'(exp_q.size()));
        n = (pulses.size() < exp_q.size()) ? pulses.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_nib%0d", tag, i), 64'(pulses[i]), 64'(exp_q[i]));
    endtask

    function automatic logic [8:0] get_byte(input int k);
        if (2*k + 1 >= pulses.size()) return 9'h1FF;
        return {pulses[2*k][4], pulses[2*k][3:0], pulses[2*k+1][3:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CCLK);
        #1;
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [255:0] rand_text();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
        return t;
    endfunction

    initial begin
        logic [255:0] t_dir, t_a, t_b;
        int lows, k;
        t_dir = {"PC=00000004     ", "IF ID EX MA WB  "};

        // Reset state and power-on init
        tick(5);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_lcde", 64'(LCDE), 64'd0);
        chk("rst_rs", 64'(LCDRS), 64'd0);
        chk("rst_dat", 64'(LCDDAT), 64'd0);
        chk("rst_rw", 64'(LCDRW), 64'd0);
        rst = 1'b0;
        pulses.delete();
        tick(10);
        chk("pwrup_no_pulse", 64'(pulses.size()), 64'd0);
        wait_busy_low("init", 3000);
        exp_q.delete();
        model_init();
        compare_model("init");
        $display("[TB] init sequence: %0d pulses", pulses.size());

`ifdef LCD_AUTO_REFRESH_EN
        begin
            int rises[$];
            logic last_b;
            last_b = busy;
            k = 0;
            while (rises.size() < 3 && k < 5000) begin
                tick(1);
                if (busy && !last_b) rises.push_back(cyc);
                last_b = busy;
                k++;
            end
            chk("auto_rises", 64'(rises.size()), 64'd3);
            for (int i = 1; i < rises.size(); i++)
                chk($sformatf("auto_interval%0d", i), 64'(rises[i] - rises[i-1]), 64'(T_REFRESH));
            $display("[TB] auto refresh: %0d starts observed", rises.size());
        end
`else
        // Directed single refresh
        pulses.delete();
        text = t_dir;
        pulse_strobe();
        chk("dir_busy_start", 64'(busy), 64'd1);
        wait_busy_low("dir", 3000);
        chk("dir_byte0", 64'(get_byte(0)), 64'h080);
        chk("dir_byte1", 64'(get_byte(1)), 64'h150);
        chk("dir_byte17", 64'(get_byte(17)), 64'h0C0);
        chk("dir_byte33", 64'(get_byte(33)), 64'h120);
        exp_q.delete();
        model_refresh(t_dir);
        compare_model("dir");
        $display("[TB] directed refresh: %0d pulses", pulses.size());

        // Randomized refreshes
        for (int it = 0; it < 3; it++) begin
            pulses.delete();
            tick($urandom_range(0, 20));
            t_a = rand_text();
            text = t_a;
            pulse_strobe();
            wait_busy_low($sformatf("rnd%0d", it), 3000);
            exp_q.delete();
            model_refresh(t_a);
            compare_model($sformatf("rnd%0d", it));
            $display("[TB] random refresh %0d: %0d pulses", it, pulses.size());
        end

        // Strobes during refresh collapse into exactly one follow-up refresh
        pulses.delete();
        t_a = rand_text();
        t_b = rand_text();
        text = t_a;
        pulse_strobe();
        tick(1);
        text = t_b;
        tick(50);  pulse_strobe();
        tick(100); pulse_strobe();
        tick(100); pulse_strobe();
        lows = 0;
        k = 0;
        while (pulses.size() < 136 && k < 5000) begin
            tick(1);
            if (busy !== 1'b1) lows++;
            k++;
        end
        chk("pend_busy_continuous", 64'(lows), 64'd0);
        wait_busy_low("pend", 3000);
        tick(300);
        exp_q.delete();
        model_refresh(t_a);
        model_refresh(t_b);
        compare_model("pend");
        $display("[TB] strobe-while-busy: %0d pulses", pulses.size());

        // Asynchronous reset while LCDE is high during LINE1
        pulses.delete();
        text = rand_text();
        pulse_strobe();
        k = 0;
        while (!(pulses.size() >= 4 && LCDE === 1'b1) && k < 3000) begin
            @(negedge CCLK);
            k++;
        end
        chk("arst_found_pulse", 64'(LCDE), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lcde_async", 64'(LCDE), 64'd0);
        chk("arst_busy", 64'(busy), 64'd1);
        tick(3);
        pulses.delete();
        rst = 1'b0;
        tick(10);
        chk("arst_pwrup_no_pulse", 64'(pulses.size()), 64'd0);
        wait_busy_low("arst_init", 3000);
        exp_q.delete();
        model_init();
        compare_model("arst_init");
        $display("[TB] reset mid-byte: init restarted with %0d pulses", pulses.size());

        // No refresh without a request
        pulses.delete();
        lows = 0;
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            if (busy !== 1'b0) lows++;
        end
        chk("idle_no_pulse", 64'(pulses.size()), 64'd0);
        chk("idle_busy_low", 64'(lows), 64'd0);
        $display("[TB] idle window: %0d pulses", pulses.size());
`endif

        chk("timing_violations", 64'(timing_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
